uart_rx_parity_engine: RTL and testbench

Serial parity checker for the UART RX path, successor to the fixed 8-bit parity check. It consumes data bits one at a time from the data sampler, accumulates parity and deserialises the frame (LSB first). It then checks the received parity bit against one of four parity modes and keeps error statistics for the control block and the register file. It sits between the data sampler and the RX control FSM.

---
 rtl/uart_rx_parity_engine_if.sv | 33 +++
 rtl/uart_rx_parity_engine.sv | 146 ++++++++++++++
 tb/tb_uart_rx_parity_engine.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_parity_engine_if.sv
// Bus between the RX data sampler / control FSM and the parity engine.
// The master side drives the configuration and the serial bits, and the
// slave side (the engine) returns the data, the check result and the
// error statistics.
interface uart_rx_parity_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int CNT_WIDTH  = 8
);
  logic                  par_en;
  logic [1:0]            par_typ;
  logic [LEN_WIDTH-1:0]  data_len;
  logic                  frame_start;
  logic                  bit_valid;
  logic                  bit_in;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  check_done;
  logic                  parity_error;
  logic                  err_sticky;
  logic [CNT_WIDTH-1:0]  err_count;
  logic                  busy;

  modport master (
    output par_en, par_typ, data_len, frame_start, bit_valid, bit_in, err_clr,
    input  data_out, check_done, parity_error, err_sticky, err_count, busy
  );

  modport slave (
    input  par_en, par_typ, data_len, frame_start, bit_valid, bit_in, err_clr,
    output data_out, check_done, parity_error, err_sticky, err_count, busy
  );
endinterface

// File: rtl/uart_rx_parity_engine.sv
// Serial parity checker for the UART RX path. It deserialises the data
// bits LSB first and accumulates their parity. It then checks the parity
// bit against the mode latched at frame_start and keeps sticky and
// saturating error statistics.
module uart_rx_parity_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  uart_rx_parity_engine_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY} state_t;
  typedef enum logic [1:0] {PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE} par_t;

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(DATA_WIDTH);

  state_t                r_state;
  state_t                w_state_next;
  par_t                  r_typ;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_acc;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_check_done;
  logic                  r_parity_error;
  logic                  r_err_sticky;
  logic [CNT_WIDTH-1:0]  r_err_count;

  logic [LEN_WIDTH-1:0]  w_eff_len;
  logic [LEN_WIDTH-1:0]  w_last_idx;
  logic                  w_check;
  logic                  w_err;

  assign w_last_idx = r_len - LEN_WIDTH'(1);

  // Effective frame length: zero or anything beyond DATA_WIDTH means full width.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    w_eff_len = bus.data_len;
    if (bus.data_len == '0 || bus.data_len > MAX_LEN) begin
      w_eff_len = MAX_LEN;
    end
  end

  // Next-state decode; frame_start overrides every state and aborts any frame.
  always_comb begin
    w_state_next = r_state;
    w_check      = 1'b0;
    if (bus.frame_start) begin
      w_state_next = bus.par_en ? ST_DATA : ST_IDLE;
    end else begin
      case (r_state)
        ST_DATA: begin
          if (bus.bit_valid && r_cnt == w_last_idx) w_state_next = ST_PARITY;
        end
        ST_PARITY: begin
          if (bus.bit_valid) begin
            w_state_next = ST_IDLE;
            w_check      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Parity error for the bit currently presented, under the latched mode.
  always_comb begin
    w_err = 1'b0;
    case (r_typ)
      PAR_EVEN:  w_err = r_acc ^ bus.bit_in;
      PAR_ODD:   w_err = ~(r_acc ^ bus.bit_in);
      PAR_MARK:  w_err = ~bus.bit_in;
      PAR_SPACE: w_err = bus.bit_in;
      default:   w_err = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: sequential state is assigned with <= so that every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Frame datapath: configuration latch, deserialiser, accumulator, result.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_typ          <= PAR_EVEN;
      r_len          <= '0;
      r_cnt          <= '0;
      r_acc          <= 1'b0;
      r_data         <= '0;
      r_check_done   <= 1'b0;
      r_parity_error <= 1'b0;
    end else begin
      r_check_done <= w_check;
      if (bus.frame_start) begin
        r_parity_error <= 1'b0;
        if (bus.par_en) begin
          r_typ  <= par_t'(bus.par_typ);
          r_len  <= w_eff_len;
          r_cnt  <= '0;
          r_acc  <= 1'b0;
          r_data <= '0;
        end
      end else if (r_state == ST_DATA && bus.bit_valid) begin
        // data_out is cleared at frame_start, so OR-ing each bit into place
        // leaves positions beyond the effective length at 0.
        r_data <= r_data | (DATA_WIDTH'(bus.bit_in) << r_cnt);
        r_acc  <= r_acc ^ bus.bit_in;
        r_cnt  <= r_cnt + LEN_WIDTH'(1);
      end else if (w_check) begin
        r_parity_error <= w_err;
      end
    end
  end

  // Error statistics; a new error wins over err_clr and counts as the first.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else if (w_check && w_err) begin
      r_err_sticky <= 1'b1;
      if (bus.err_clr)          r_err_count <= CNT_WIDTH'(1);
      else if (r_err_count != '1) r_err_count <= r_err_count + CNT_WIDTH'(1);
    end else if (bus.err_clr) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end
  end

  assign bus.data_out     = r_data;
  assign bus.check_done   = r_check_done;
  assign bus.parity_error = r_parity_error;
  assign bus.err_sticky   = r_err_sticky;
  assign bus.err_count    = r_err_count;
  assign bus.busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_parity_engine.sv
// Directed testbench for uart_rx_parity_engine. Inputs change and outputs
// are sampled on the falling clock edge, away from the active rising edge.
module tb_uart_rx_parity_engine;

  localparam int DATA_WIDTH = 8;
  localparam int LEN_WIDTH  = 4;
  localparam int CNT_WIDTH  = 8;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;
  int   n_done;

  uart_rx_parity_engine_if #(
    .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) bus ();

  uart_rx_parity_engine #(
    .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Counts the cycles check_done is high, to catch pulses from aborted frames.
  initial n_done = 0;
  always @(posedge CLK) if (bus.check_done) n_done++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_frame(input logic en, input logic [1:0] typ, input logic [3:0] len);
    bus.frame_start = 1'b1;
    bus.par_en      = en;
    bus.par_typ     = typ;
    bus.data_len    = len;
    @(negedge CLK);
    bus.frame_start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic clr);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    bus.err_clr   = clr;
    @(negedge CLK);
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.err_clr   = 1'b0;
  endtask

  // Whole frame; returns on the falling edge where check_done should be high.
  task automatic send_frame(input logic [1:0] typ, input logic [3:0] len,
                            input logic [15:0] data, input int nbits,
                            input logic par, input logic clr_on_par);
    start_frame(1'b1, typ, len);
    for (int i = 0; i < nbits; i++) send_bit(data[i], 1'b0);
    send_bit(par, clr_on_par);
  endtask

  initial begin
    int done_before;
    n_checks = 0;
    n_errors = 0;
    RST = 1'b0;
    bus.par_en = 1'b0; bus.par_typ = 2'b00; bus.data_len = '0;
    bus.frame_start = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.err_clr = 1'b0;

    // Reset state
    #3;
    check("rst_data_out",   bus.data_out, 0);
    check("rst_check_done", bus.check_done, 0);
    check("rst_par_err",    bus.parity_error, 0);
    check("rst_sticky",     bus.err_sticky, 0);
    check("rst_count",      bus.err_count, 0);
    check("rst_busy",       bus.busy, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // 1: even, len 8, 0xA5 (four ones), parity 0 -> good
    start_frame(1'b1, 2'b00, 4'd8);
    check("t1_busy_data", bus.busy, 1);
    for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h01) != 0, 1'b0);
    check("t1_no_done_early", bus.check_done, 0);
    check("t1_busy_parity", bus.busy, 1);
    send_bit(1'b0, 1'b0);
    check("t1_done",     bus.check_done, 1);
    check("t1_par_err",  bus.parity_error, 0);
    check("t1_data",     bus.data_out, 8'hA5);
    check("t1_count",    bus.err_count, 0);
    check("t1_busy_end", bus.busy, 0);
    @(negedge CLK);
    check("t1_done_pulse", bus.check_done, 0);
    check("t1_data_held",  bus.data_out, 8'hA5);

    // 2: odd, len 7, 0x13 (three ones, acc=1), parity 1 -> ~(1^1)=1 error
    send_frame(2'b01, 4'd7, 16'h0013, 7, 1'b1, 1'b0);
    check("t2_done",    bus.check_done, 1);
    check("t2_par_err", bus.parity_error, 1);
    check("t2_sticky",  bus.err_sticky, 1);
    check("t2_count",   bus.err_count, 1);
    check("t2_data",    bus.data_out, 8'h13);
    @(negedge CLK);
    check("t2_err_held", bus.parity_error, 1);
    // Same data, parity 0 -> ~(1^0)=0 no error; sticky stays set
    send_frame(2'b01, 4'd7, 16'h0013, 7, 1'b0, 1'b0);
    check("t2b_par_err", bus.parity_error, 0);
    check("t2b_sticky",  bus.err_sticky, 1);
    check("t2b_count",   bus.err_count, 1);

    // err_clr with no error clears both statistics
    bus.err_clr = 1'b1;
    @(negedge CLK);
    bus.err_clr = 1'b0;
    check("clr_sticky", bus.err_sticky, 0);
    check("clr_count",  bus.err_count, 0);

    // 3: mark, len 0 (= 8 bits), 0x3C, parity 0 -> error
    send_frame(2'b10, 4'd0, 16'h003C, 8, 1'b0, 1'b0);
    check("t3_mark_done",  bus.check_done, 1);
    check("t3_mark_err",   bus.parity_error, 1);
    check("t3_mark_count", bus.err_count, 1);
    check("t3_mark_data",  bus.data_out, 8'h3C);
    // space, len 12 (> DATA_WIDTH -> 8 bits), 0x81, parity 0 -> good
    send_frame(2'b11, 4'd12, 16'h0081, 8, 1'b0, 1'b0);
    check("t3_space_done",  bus.check_done, 1);
    check("t3_space_err",   bus.parity_error, 0);
    check("t3_space_count", bus.err_count, 1);
    check("t3_space_data",  bus.data_out, 8'h81);
    // even, len 5, five ones (acc=1), parity 1 -> good; upper bits read 0
    send_frame(2'b00, 4'd5, 16'h001F, 5, 1'b1, 1'b0);
    check("t3_len5_done", bus.check_done, 1);
    check("t3_len5_err",  bus.parity_error, 0);
    check("t3_len5_data", bus.data_out, 8'h1F);

    // 4: 260 bad mark frames on top of count 1 -> saturates at 255
    for (int f = 0; f < 260; f++) send_frame(2'b10, 4'd5, 16'h0000, 5, 1'b0, 1'b0);
    check("t4_sat_count",  bus.err_count, 255);
    check("t4_sat_sticky", bus.err_sticky, 1);
    // err_clr on the same cycle as a new error
    send_frame(2'b10, 4'd5, 16'h0000, 5, 1'b0, 1'b1);
    check("t4_clr_err_count",  bus.err_count, 1);
    check("t4_clr_err_sticky", bus.err_sticky, 1);
    bus.err_clr = 1'b1;
    @(negedge CLK);
    bus.err_clr = 1'b0;
    check("t4_clr_count",  bus.err_count, 0);
    check("t4_clr_sticky", bus.err_sticky, 0);

    // 5: abort after 4 of 8 data bits, then a complete 0x5A even frame
    @(negedge CLK);
    done_before = n_done;
    start_frame(1'b1, 2'b00, 4'd8);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    check("t5_partial_data", bus.data_out, 8'h0F);
    start_frame(1'b1, 2'b00, 4'd8);
    check("t5_restart_data", bus.data_out, 0);
    check("t5_restart_busy", bus.busy, 1);
    for (int i = 0; i < 8; i++) send_bit(((8'h5A >> i) & 8'h01) != 0, 1'b0);
    send_bit(1'b0, 1'b0);
    check("t5_done",    bus.check_done, 1);
    check("t5_par_err", bus.parity_error, 0);
    check("t5_data",    bus.data_out, 8'h5A);
    @(negedge CLK);
    check("t5_one_done", n_done - done_before, 1);
    // Bad even frame (0x01, parity 0), then a par_en=0 frame clears parity_error
    send_frame(2'b00, 4'd8, 16'h0001, 8, 1'b0, 1'b0);
    check("t5_bad_err", bus.parity_error, 1);
    @(negedge CLK);
    done_before = n_done;
    start_frame(1'b0, 2'b00, 4'd8);
    check("t5_off_err_clr", bus.parity_error, 0);
    check("t5_off_busy",    bus.busy, 0);
    for (int i = 0; i < 9; i++) begin
      send_bit(1'b1, 1'b0);
      check("t5_off_busy_bit", bus.busy, 0);
    end
    @(negedge CLK);
    check("t5_off_no_done", n_done - done_before, 0);

    // 6: asynchronous reset in the middle of DATA
    start_frame(1'b1, 2'b00, 4'd8);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    check("t6_pre_count", bus.err_count, 1);
    #2 RST = 1'b0;
    #1;
    check("t6_rst_data",   bus.data_out, 0);
    check("t6_rst_busy",   bus.busy, 0);
    check("t6_rst_count",  bus.err_count, 0);
    check("t6_rst_sticky", bus.err_sticky, 0);
    check("t6_rst_done",   bus.check_done, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    send_frame(2'b00, 4'd8, 16'h00FF, 8, 1'b0, 1'b0);
    check("t6_done",    bus.check_done, 1);
    check("t6_par_err", bus.parity_error, 0);
    check("t6_data",    bus.data_out, 8'hFF);
    check("t6_count",   bus.err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
